// File: rtl/rng_req_arbiter.sv
// Shared 16-bit Galois LFSR word server, round-robin over NUM_REQ requesters; one-cycle grant latency, no backpressure (req held until gnt).
// Optional reseed port and re-load path enabled by RNG_ARB_RESEED_EN.
module rng_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        seed_in,
`ifdef RNG_ARB_RESEED_EN
  input  logic               reseed,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        rnd_data,
  output logic               rnd_valid,
  output logic               busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] SEED_DFLT = 16'hACE1;

  typedef enum logic [1:0] {S_LOAD, S_WARM, S_IDLE} state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [7:0]         cnt;
  logic [PW-1:0]      ptr;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win_oh;
  logic [PW-1:0]      win;
  logic [PW-1:0]      ptr_nxt;
  logic               found;
  logic               reseed_i;

`ifdef RNG_ARB_RESEED_EN
  assign reseed_i = reseed;
`else
  assign reseed_i = 1'b0;
`endif

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // The requester granted last cycle is masked so one request yields one word.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    elig   = req & ~gnt;
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    idx    = 0;
    idx_p  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_p = PW'(idx);
      if (!found && elig[idx_p]) begin
        found = 1'b1;
        win   = idx_p;
      end
    end
    win_oh[win] = found;
    ptr_nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD;
      lfsr      <= SEED_DFLT;
      cnt       <= '0;
      ptr       <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      busy      <= 1'b1;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      case (state)
        S_LOAD: begin
          lfsr  <= (seed_in == 16'h0000) ? SEED_DFLT : seed_in;
          cnt   <= '0;
          state <= S_WARM;
          busy  <= 1'b1;
        end
        S_WARM: begin
          if (reseed_i) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end else begin
            lfsr <= lfsr_step(lfsr);
            cnt  <= cnt + 8'd1;
            if (cnt == 8'(WARMUP - 1)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        S_IDLE: begin
          // Reseed takes priority: no grant and no LFSR step this cycle.
          if (reseed_i) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end else if (found) begin
            gnt       <= win_oh;
            rnd_valid <= 1'b1;
            rnd_data  <= lfsr;
            lfsr      <= lfsr_step(lfsr);
            ptr       <= ptr_nxt;
          end
        end
        default: begin
          state <= S_LOAD;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_req_arbiter.sv
// Scoreboard bench for rng_req_arbiter: stimulus pushes expected grants, negedge monitors pop and compare.
module tb_rng_req_arbiter;

  typedef struct {
    logic [3:0]  g;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] seed_in = 16'd5555;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  gnt;
  logic [15:0] rnd_data;
  logic        rnd_valid;
  logic        busy;
  logic        reseed = 1'b0;

  logic [15:0] seed_b = 16'h0000;
  logic [3:0]  req_b = 4'b0000;
  logic [3:0]  gnt_b;
  logic [15:0] rnd_data_b;
  logic        rnd_valid_b;
  logic        busy_b;

  int total = 0;
  int bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [15:0] m;
  logic [15:0] last_a = 16'h0000;

  always #5 clk = ~clk;

  rng_req_arbiter #(.NUM_REQ(4), .WARMUP(8)) dut_a (
    .clk(clk), .rst(rst), .seed_in(seed_in),
`ifdef RNG_ARB_RESEED_EN
    .reseed(reseed),
`endif
    .req(req), .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .busy(busy)
  );

  rng_req_arbiter #(.NUM_REQ(4), .WARMUP(1)) dut_b (
    .clk(clk), .rst(rst), .seed_in(seed_b),
`ifdef RNG_ARB_RESEED_EN
    .reseed(1'b0),
`endif
    .req(req_b), .gnt(gnt_b), .rnd_data(rnd_data_b), .rnd_valid(rnd_valid_b), .busy(busy_b)
  );

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [3:0] g, input logic [15:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    qa.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_a = 16'h0000;
    end else begin
      chk("valid_vs_gnt", {31'd0, rnd_valid}, {31'd0, |gnt});
      if (rnd_valid) begin
        if (qa.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant actual gnt=%b data=%h required none", gnt, rnd_data);
        end else begin
          e = qa.pop_front();
          chk("gnt", {28'd0, gnt}, {28'd0, e.g});
          chk("rnd_data", {16'd0, rnd_data}, {16'd0, e.d});
        end
        last_a = rnd_data;
      end else begin
        chk("rnd_data_hold", {16'd0, rnd_data}, {16'd0, last_a});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rnd_valid_b) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant_b actual gnt=%b data=%h required none", gnt_b, rnd_data_b);
      end else begin
        e = qb.pop_front();
        chk("gnt_b", {28'd0, gnt_b}, {28'd0, e.g});
        chk("rnd_data_b", {16'd0, rnd_data_b}, {16'd0, e.d});
      end
    end
  end

  initial begin
    exp_t eb;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_valid", {31'd0, rnd_valid}, 32'd0);
    chk("rst_data", {16'd0, rnd_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);

    // Zero-seed instance: single warm step from ACE1.
    req_b = 4'b0001;
    eb.g = 4'b0001;
    eb.d = 16'hE270;
    qb.push_back(eb);
    rst = 1'b0;

    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      chk("warm_busy", {31'd0, busy}, (i < 9) ? 32'd1 : 32'd0);
      if (i == 3) req_b = 4'b0000;
    end

    // Round-robin with all requesters asserted.
    m = 16'h15B3;
    repeat (8) m = step(m);
    for (int k = 0; k < 8; k++) begin
      push_a(4'b0001 << (k % 4), m);
      m = step(m);
    end
    req = 4'b1111;
    repeat (8) @(posedge clk);
    #1;

    // Single requester: granted every other cycle.
    for (int k = 0; k < 4; k++) begin
      push_a(4'b0100, m);
      m = step(m);
    end
    req = 4'b0100;
    repeat (8) @(posedge clk);
    #1;

    // Reset while requester 1 holds its grant.
    req = 4'b0010;
    @(posedge clk);
    #1;
    chk("pre_rst_gnt", {28'd0, gnt}, 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_valid", {31'd0, rnd_valid}, 32'd0);
    chk("mid_rst_data", {16'd0, rnd_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    seed_in = 16'h1234;
    m = 16'h1234;
    repeat (8) m = step(m);
    push_a(4'b0010, m);
    m = step(m);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rewarm_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    req = 4'b0000;

`ifdef RNG_ARB_RESEED_EN
    // Reseed beats a same-cycle request.
    repeat (3) @(posedge clk);
    #1;
    seed_in = 16'hBEEF;
    req = 4'b0001;
    reseed = 1'b1;
    @(posedge clk);
    #1;
    reseed = 1'b0;
    chk("reseed_no_gnt", {28'd0, gnt}, 32'd0);
    chk("reseed_busy", {31'd0, busy}, 32'd1);
    m = 16'hBEEF;
    repeat (8) m = step(m);
    push_a(4'b0001, m);
    repeat (9) @(posedge clk);
    #1;
    chk("reseed_warm_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    req = 4'b0000;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("queue_a_drained", qa.size(), 32'd0);
    chk("queue_b_drained", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rng_req_arbiter.md
# rng_req_arbiter

Shared random-number service for the RNG-2D design. Owns one 16-bit Galois LFSR, seeded by the same value that drives `random_mod`, and hands fresh words to up to `NUM_REQ` requesters. A round-robin arbiter grants one requester per cycle. A warm-up sequencer advances the LFSR after every (re)seed before any word is released.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WARMUP`, default 8: LFSR steps discarded after each seed load, 1..255.
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `seed_in`  in  16: seed value, sampled in the LOAD state.
- `reseed`  in  1: reseed request pulse. Present only with `RNG_ARB_RESEED_EN`.
- `req`  in  NUM_REQ: per-requester request level. Held high until that requester's `gnt` bit is seen.
- `gnt`  out  NUM_REQ: one-hot, single-cycle grant pulse, registered.
- `rnd_data`  out  16: random word for the granted requester. Valid only while `rnd_valid` is high.
- `rnd_valid`  out  1: high exactly in the cycles when `gnt` is non-zero.
- `busy`  out  1: high in LOAD and WARM.

## Operation
- LFSR step: `s = (s >> 1) ^ (s[0] ? 16'hB400 : 0)`. A seed of 0 is replaced by 16'hACE1.
- States:
  - RESET → LOAD (async): lfsr=16'hACE1, warm counter=0, RR pointer=0.
  - LOAD (1 cycle): lfsr ← seed_in (or 16'hACE1 if zero), counter cleared, → WARM.
  - WARM: one LFSR step per cycle, counter+1. After `WARMUP` steps → IDLE.
  - IDLE: serves requests, see below.
- Eligible requesters in IDLE: `req & ~gnt`. The requester holding `gnt` this cycle is masked out, so it cannot be granted twice for one request.
- Winner: first eligible index at or above the RR pointer, searching upward and wrapping at `NUM_REQ-1` to 0.
- On a grant edge:
  - `gnt[w]`=1 and `rnd_data`=current lfsr are registered.
  - The LFSR steps.
  - RR pointer ← (w+1) mod NUM_REQ.
- No eligible request: `gnt`=0, `rnd_valid`=0, LFSR holds, `rnd_data` holds its last value.
- Every granted word is distinct in sequence; the LFSR steps only on grants and during WARM.
- `req` is ignored in LOAD/WARM. Pending requests are served once IDLE is reached.

## Timing
- Reset values: `gnt`=0, `rnd_valid`=0, `rnd_data`=0, `busy`=1.
- `busy` falls on the edge that enters IDLE, 1+`WARMUP` cycles after `rst` is released.
- Grant latency: `req` high at edge k (in IDLE) → `gnt` high in the cycle following edge k.
- Throughput:
  - Distinct requesters can be granted on back-to-back cycles.
  - A single requester is granted at most every other cycle, because of the mask.
- All outputs are registered; no combinational path from `req` to `gnt`.
- If `rst` is asserted mid-operation, outputs clear immediately and an in-flight grant is lost. The requester keeps `req` high and is re-served after warm-up.
- An index ≥ `NUM_REQ` never appears in `gnt`.

## Configuration
- `RNG_ARB_RESEED_EN` defined:
  - The `reseed` port exists.
  - `reseed` sampled high in IDLE or WARM → LOAD on the next edge. The counter restarts.
  - `reseed` wins over a same-cycle grant: no `gnt` that cycle, and the LFSR does not step.
  - `reseed` in LOAD is ignored.
- `RNG_ARB_RESEED_EN` undefined: the port is absent. The seed loads only after `rst`.

## Test plan
- Reset → warm-up: `seed_in`=16'd5555, `WARMUP`=8, release `rst` → `busy`=1 for 9 cycles then 0. The first granted word equals a bench model of the LFSR stepped 8 times from 16'h15B3.
- Zero seed: `seed_in`=0, `WARMUP`=1 → first granted word = 16'hE270 (one step from 16'hACE1).
- Round-robin: `req`=4'b1111 held continuously → `gnt` sequence 0001, 0010, 0100, 1000, 0001… Each word equals the model's successive LFSR states.
- Single requester: `req[2]` held high → `gnt`=0100 on alternating cycles only. `rnd_valid` matches `gnt` every cycle.
- Reset mid-grant: assert `rst` in the cycle `gnt`=0010 → `gnt`/`rnd_valid`/`rnd_data` = 0 immediately, `busy`=1. After warm-up, requester 1 is served again.
- Reseed (macro on): `req`=4'b0001 and `reseed`=1 in the same IDLE cycle → no grant. LOAD, then `WARMUP` cycles of WARM, then the grant uses the new-seed sequence.
